eaglesong_digest_host: RTL and testbench
========================================

Name: eaglesong_digest_host

Overview:
Byte-stream front end that drives eaglesong_digest_top from its initiator side. It packs a framed message of 1..32 bytes into input_val / input_length_bytes and issues start_eval. It then waits for the digest and serialises the 256-bit output_val back out as 32 bytes over a valid/ready stream. It sits between the system byte interface and eaglesong_digest_top, replacing the hand-driven stimulus used today.

Parameters:
START_CYCLES, 2, number of cycles start_eval is held high per message (legal range 1..7)
TIMEOUT_CYCLES, 120, cycles allowed in WAIT_LOW plus WAIT_HIGH before a timeout is declared (legal range 1..1023)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
in_byte  input  8  message byte
in_valid  input  1  in_byte valid
in_last  input  1  final byte of message, qualified by in_valid
in_ready  output  1  host accepts in_byte this cycle
input_val  output  256  packed message to core; byte k at [8k+7:8k]
input_length_bytes  output  7  message length to core, 1..32
start_eval  output  1  start strobe to core
output_val  input  256  digest from core
eval_output_ready  input  1  core digest-valid level
dig_byte  output  8  digest byte; byte k of output_val sent k-th, k=0 first
dig_valid  output  1  dig_byte valid
dig_last  output  1  marks byte 31
dig_ready  input  1  sink accepts dig_byte
err_overlength  output  1  one-cycle pulse: message exceeded 32 bytes
err_timeout  output  1  one-cycle pulse: digest not returned in time
busy  output  1  high in every state except COLLECT with zero bytes held

Behaviour:
- Reset (reset_n=0 at a clk edge), any state: state=COLLECT; byte count=0; input_val=0; input_length_bytes=0; start_eval=0; dig_valid=0; dig_last=0; dig_byte=0; err_*=0; busy=0; in_ready=1 after reset releases. Reset mid-operation abandons the message and the digest with no error pulse.
- COLLECT: in_ready=1. A transfer is in_valid&in_ready. Byte n (0-based) is written to input_val[8n+7:8n]. Bytes above the current count keep their cleared value. input_val is zeroed on entry to COLLECT.
  - Transfer with in_last at count n<=31: input_length_bytes=n+1; go to START next cycle.
  - Transfer at count 32 without in_last: pulse err_overlength; go to DRAIN.
  - Transfer at count 32 with in_last: pulse err_overlength; go to COLLECT (cleared).
- DRAIN: in_ready=1. Discard bytes until a transfer with in_last, then go to COLLECT. No start_eval is issued.
- START: in_ready=0. start_eval=1 for exactly START_CYCLES cycles. input_val and input_length_bytes stay stable from START entry until the digest is captured. Then go to WAIT_LOW.
- WAIT_LOW: wait for eval_output_ready=0, which rejects a stale ready level left over from the previous digest. On seeing 0, go to WAIT_HIGH.
- WAIT_HIGH: on the first cycle eval_output_ready=1, capture output_val into a 256-bit shift register and go to EMIT.
- Timeout: one 10-bit counter runs across WAIT_LOW and WAIT_HIGH. When it reaches TIMEOUT_CYCLES without capture, pulse err_timeout and go to COLLECT. No digest bytes are emitted.
- EMIT: dig_valid=1 and dig_byte=shift[7:0]. On dig_valid&dig_ready, shift right by 8 and increment the index. dig_last=1 when the index is 31. A handshake on the last byte leads to COLLECT next cycle with dig_valid=0.
  - dig_byte is held stable while dig_ready=0; stalls are unbounded.
  - in_ready=0 throughout EMIT, so the next message cannot start until the digest is fully drained.
- Latency, last input byte to first dig_valid: 1 + START_CYCLES + core latency + 2 (WAIT_LOW/WAIT_HIGH sampling).
- Only one message is in flight at a time; there is no input buffering.

Optional Feature:
EAGLESONG_HOST_TIMEOUT_EN
- Defined: timeout counter and err_timeout behave as described above.
- Undefined: the counter is not built; err_timeout is tied to 0; WAIT_LOW and WAIT_HIGH wait indefinitely. TIMEOUT_CYCLES is ignored.

Test Plan:
- Hello world: send 14 bytes 48 65 6C 6C 6F 2C 20 77 6F 72 6C 64 21 0A (last on 0A) with core attached -> input_val=256'h0A21646C726F77202C6F6C6C6548; input_length_bytes=14; start_eval high 2 cycles; dig stream 64 86 7E 24 ... 07 7D 72 D6 (32 bytes, dig_last on D6); no err pulses.
- Full length: send 32 bytes 00..1F -> input_length_bytes=32; input_val[255:248]=1F; one digest of 32 bytes emitted; err_overlength stays 0.
- Overlength: send 40 bytes with in_last on byte 40 -> err_overlength pulses once on byte 33; start_eval never asserts; in_ready stays 1; the next message processes normally.
- Timeout (macro defined): core stub holds eval_output_ready=0 -> err_timeout pulses exactly 120 cycles after WAIT_LOW entry; no dig_valid; state returns to COLLECT.
- Backpressure plus stale ready: core stub holds eval_output_ready=1 before start and drops it 1 cycle after start_eval falls; dig_ready toggles 1,0,0,1 -> no early capture; dig_byte held during stalls; exactly 32 handshakes.
- Reset mid-operation: assert reset_n=0 for 1 cycle during EMIT at byte 10 -> next cycle all outputs at reset values; a fresh message then completes correctly.

Source files
------------

// File: rtl/eaglesong_digest_host_if.sv
// eaglesong_digest_host_if: byte-in, core-side and digest-out signals of the eaglesong host
interface eaglesong_digest_host_if;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [255:0] input_val;
  logic [6:0]   input_length_bytes;
  logic         start_eval;
  logic [255:0] output_val;
  logic         eval_output_ready;
  logic [7:0]   dig_byte;
  logic         dig_valid;
  logic         dig_last;
  logic         dig_ready;
  logic         err_overlength;
  logic         err_timeout;
  logic         busy;
  modport master (
    output in_byte, in_valid, in_last, output_val, eval_output_ready, dig_ready,
    input  in_ready, input_val, input_length_bytes, start_eval, dig_byte, dig_valid, dig_last,
           err_overlength, err_timeout, busy
  );
  modport slave (
    input  in_byte, in_valid, in_last, output_val, eval_output_ready, dig_ready,
    output in_ready, input_val, input_length_bytes, start_eval, dig_byte, dig_valid, dig_last,
           err_overlength, err_timeout, busy
  );
endinterface

// File: rtl/eaglesong_digest_host.sv
// eaglesong_digest_host: packs a byte message for eaglesong_digest_top and streams the digest back; EAGLESONG_HOST_TIMEOUT_EN enables the digest timeout
module eaglesong_digest_host #(
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 120
) (
  input logic clk,
  input logic reset_n,
  eaglesong_digest_host_if.slave bus
);
  typedef enum logic [2:0] {COLLECT, DRAIN, START, WAIT_LOW, WAIT_HIGH, EMIT} state_t;
  state_t state, state_n;
  logic [5:0] cnt;
  logic [2:0] scnt;
  logic [4:0] idx;
  logic [255:0] val, shift;
  logic [6:0] len;
  logic ovf_q, tmo_q, xfer, hs, cap, ovf, tmo_hit, clear;
  if (START_CYCLES < 1 || START_CYCLES > 7) begin : g_bad_start
    $error("START_CYCLES must be 1..7");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..1023");
  end
  assign xfer = bus.in_valid && bus.in_ready;
  assign hs = state == EMIT && bus.dig_ready;
  assign cap = state == WAIT_HIGH && bus.eval_output_ready;
  assign ovf = state == COLLECT && xfer && cnt == 6'd32;
`ifdef EAGLESONG_HOST_TIMEOUT_EN
  logic [9:0] tmo;
  always_ff @(posedge clk)
    if (!reset_n || state == START) tmo <= '0;
    else if (state == WAIT_LOW || state == WAIT_HIGH) tmo <= tmo + 10'd1;
  // a capture on the final allowed cycle wins over the timeout
  assign tmo_hit = (state == WAIT_LOW || (state == WAIT_HIGH && !bus.eval_output_ready))
                   && tmo == 10'(TIMEOUT_CYCLES - 1);
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      COLLECT:   if (xfer) state_n = cnt == 6'd32 ? (bus.in_last ? COLLECT : DRAIN) : (bus.in_last ? START : COLLECT);
      DRAIN:     if (xfer && bus.in_last) state_n = COLLECT;
      START:     if (scnt == 3'(START_CYCLES - 1)) state_n = WAIT_LOW;
      WAIT_LOW:  state_n = tmo_hit ? COLLECT : bus.eval_output_ready ? WAIT_LOW : WAIT_HIGH;
      WAIT_HIGH: state_n = cap ? EMIT : tmo_hit ? COLLECT : WAIT_HIGH;
      EMIT:      if (hs && idx == 5'd31) state_n = COLLECT;
      default:   state_n = COLLECT;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) state <= COLLECT;
    else state <= state_n;
  assign clear = state_n == COLLECT && (state != COLLECT || ovf);
  always_ff @(posedge clk)
    if (!reset_n) begin
      cnt <= '0;
      scnt <= '0;
      idx <= '0;
      val <= '0;
      len <= '0;
      shift <= '0;
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      ovf_q <= ovf;
      tmo_q <= tmo_hit;
      scnt <= state == START ? scnt + 3'd1 : 3'd0;
      if (clear) begin
        cnt <= '0;
        val <= '0;
      end else if (state == COLLECT && xfer && cnt != 6'd32) begin
        val[{cnt[4:0], 3'b000} +: 8] <= bus.in_byte;
        cnt <= cnt + 6'd1;
        if (bus.in_last) len <= 7'(cnt) + 7'd1;
      end
      if (cap) shift <= bus.output_val;
      else if (hs) shift <= {8'h00, shift[255:8]};
      if (hs) idx <= idx + 5'd1;
    end
  assign bus.in_ready = state == COLLECT || state == DRAIN;
  assign bus.input_val = val;
  assign bus.input_length_bytes = len;
  assign bus.start_eval = state == START;
  assign bus.dig_valid = state == EMIT;
  assign bus.dig_byte = shift[7:0];
  assign bus.dig_last = state == EMIT && idx == 5'd31;
  assign bus.err_overlength = ovf_q;
  assign bus.err_timeout = tmo_q;
  assign bus.busy = !(state == COLLECT && cnt == 6'd0);
endmodule

// File: tb/tb_eaglesong_digest_host.sv
// tb_eaglesong_digest_host: table-driven and randomized checks of the host against a core stub and a message-level model
module tb_eaglesong_digest_host;
  localparam int START = 2;
  localparam int TMO = 120;
  typedef struct {
    int kind;
    int n;
    bit stale;
    bit bp;
    int lat;
    int exp_starts;
    int exp_ovf;
  } vec_t;
  logic clk = 1'b1;
  logic reset_n;
  int vectors, miscompares;
  int st_total, ovf_total, tmo_total, pidx, stub_mode, stub_lat, stub_cnt;
  logic bp, armed, prev_stall, st_prev;
  logic [7:0] prev_byte;
  logic [255:0] pend, cap_val;
  logic [6:0] cap_len;
  logic [8:0] dig_q[$];
  logic [7:0] msg[$];
  logic [7:0] hello[14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                            8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
  vec_t tv[10];
  eaglesong_digest_host_if bus();
  eaglesong_digest_host #(.START_CYCLES(START), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // stand-in for the core: digest is an arbitrary position-dependent scramble of the message
  function automatic logic [255:0] mix(input logic [255:0] v, input logic [6:0] n);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = v[8*((k*7+3)%32) +: 8] ^ 8'(k * int'(n)) ^ 8'h5A;
    return r;
  endfunction
  function automatic logic [255:0] pack();
    logic [255:0] r = '0;
    for (int i = 0; i < msg.size() && i < 32; i++) r[8*i +: 8] = msg[i];
    return r;
  endfunction
  // core stub: mode 0 normal, 1 stale ready held high through start, 2 never answers
  always @(negedge clk)
    if (!reset_n) begin
      armed = 1'b0;
      bus.eval_output_ready = 1'b0;
      bus.output_val = {32{8'hEE}};
    end else if (bus.start_eval) begin
      pend = mix(bus.input_val, bus.input_length_bytes);
      armed = 1'b1;
      stub_cnt = 0;
      bus.eval_output_ready = stub_mode == 1;
    end else if (armed) begin
      stub_cnt++;
      if (stub_mode == 1 && stub_cnt == 1) bus.eval_output_ready = 1'b0;
      if (stub_mode != 2 && stub_cnt == stub_lat) begin
        bus.eval_output_ready = 1'b1;
        bus.output_val = pend;
        armed = 1'b0;
      end
    end
  // monitor: records start/error/digest events and drives dig_ready
  always @(negedge clk)
    if (!reset_n) begin
      prev_stall = 1'b0;
      st_prev = 1'b0;
      bus.dig_ready = 1'b0;
    end else begin
      if (bus.start_eval) begin
        if (!st_prev) begin
          cap_val = bus.input_val;
          cap_len = bus.input_length_bytes;
        end else begin
          check("input_val_stable", bus.input_val, cap_val);
        end
        st_total++;
      end
      st_prev = bus.start_eval;
      if (bus.err_overlength) ovf_total++;
      if (bus.err_timeout) tmo_total++;
      if (prev_stall && bus.dig_valid) check("dig_hold", bus.dig_byte, prev_byte);
      pidx++;
      bus.dig_ready = bp ? (pidx % 4 == 0 || pidx % 4 == 3) : 1'($urandom_range(1));
      if (bus.dig_valid && bus.dig_ready) dig_q.push_back({bus.dig_last, bus.dig_byte});
      prev_stall = bus.dig_valid && !bus.dig_ready;
      prev_byte = bus.dig_byte;
    end
  task automatic send(input int ovf_idx);
    for (int i = 0; i < msg.size(); i++) begin
      @(negedge clk);
      if (i > 0) check("err_overlength", bus.err_overlength, 1'((i - 1) == ovf_idx));
      while ($urandom_range(3) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      check("in_ready", bus.in_ready, 1);
      bus.in_byte = msg[i];
      bus.in_valid = 1'b1;
      bus.in_last = i == msg.size() - 1;
    end
    @(negedge clk);
    check("err_overlength", bus.err_overlength, 1'((msg.size() - 1) == ovf_idx));
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic fill(input int kind, input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(kind == 1 ? hello[i] : kind == 2 ? 8'(i) : 8'($urandom));
  endtask
  task automatic check_reset();
    check("rst_dig_valid", bus.dig_valid, 0);
    check("rst_dig_last", bus.dig_last, 0);
    check("rst_dig_byte", bus.dig_byte, 0);
    check("rst_input_val", bus.input_val, 0);
    check("rst_input_len", bus.input_length_bytes, 0);
    check("rst_start_eval", bus.start_eval, 0);
    check("rst_err", {bus.err_overlength, bus.err_timeout}, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
  endtask
  task automatic run_vec(input vec_t v);
    int sb, ob, tb0, db, nd;
    logic [255:0] exp;
    fill(v.kind, v.n);
    stub_mode = v.stale ? 1 : 0;
    stub_lat = v.lat;
    bp = v.bp;
    sb = st_total;
    ob = ovf_total;
    tb0 = tmo_total;
    db = dig_q.size();
    send(v.exp_ovf != 0 ? 32 : -1);
    if (v.exp_starts != 0) begin
      for (int c = 0; c < 4000 && !(dig_q.size() - db >= 32 && !bus.busy); c++) @(negedge clk);
      check("digest_done", 1'(dig_q.size() - db >= 32 && !bus.busy), 1);
    end
    repeat (4) @(negedge clk);
    nd = dig_q.size() - db;
    check("start_cycles", st_total - sb, v.exp_starts);
    check("ovf_pulses", ovf_total - ob, v.exp_ovf);
    check("tmo_pulses", tmo_total - tb0, 0);
    check("dig_count", nd, v.exp_starts != 0 ? 32 : 0);
    check("busy_idle", bus.busy, 0);
    check("in_ready_idle", bus.in_ready, 1);
    if (v.exp_starts != 0) begin
      exp = mix(pack(), 7'(v.n));
      check("input_len", cap_len, v.n);
      check("input_val", cap_val, pack());
      if (v.kind == 1) check("hello_val", cap_val, 256'h0A21646C726F77202C6F6C6C6548);
      if (v.kind == 2) check("full_top_byte", cap_val[255:248], 8'h1F);
      for (int k = 0; k < 32 && k < nd; k++) check("dig_byte", dig_q[db + k], {k == 31, exp[8*k +: 8]});
    end
  endtask
`ifdef EAGLESONG_HOST_TIMEOUT_EN
  task automatic timeout_test();
    int n, db, tb0;
    n = 0;
    db = dig_q.size();
    tb0 = tmo_total;
    fill(0, 8);
    stub_mode = 2;
    send(-1);
    for (int c = 0; c < 20 && bus.start_eval; c++) @(negedge clk);
    while (!bus.err_timeout && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TMO);
    check("timeout_busy", bus.busy, 0);
    @(negedge clk);
    check("timeout_pulse_width", bus.err_timeout, 0);
    check("timeout_pulses", tmo_total - tb0, 1);
    check("timeout_no_digest", dig_q.size() - db, 0);
    check("timeout_in_ready", bus.in_ready, 1);
    stub_mode = 0;
  endtask
`endif
  task automatic reset_mid_emit();
    int db;
    fill(0, 20);
    stub_mode = 0;
    stub_lat = 5;
    bp = 1'b0;
    db = dig_q.size();
    send(-1);
    for (int c = 0; c < 2000 && dig_q.size() - db < 10; c++) @(negedge clk);
    check("emit_reached", 1'(dig_q.size() - db >= 10 && bus.dig_valid), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset();
    reset_n = 1'b1;
  endtask
  initial begin
    bus.in_byte = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    reset_n = 1'b0;
    stub_mode = 0;
    stub_lat = 4;
    bp = 1'b0;
    tv[0] = '{1, 14, 1'b0, 1'b0, 6, START, 0};
    tv[1] = '{2, 32, 1'b0, 1'b0, 4, START, 0};
    tv[2] = '{0, 40, 1'b0, 1'b0, 5, 0, 1};
    tv[3] = '{0, 33, 1'b0, 1'b0, 5, 0, 1};
    tv[4] = '{0, 1, 1'b1, 1'b1, 7, START, 0};
    tv[5] = '{0, 32, 1'b1, 1'b1, 3, START, 0};
    for (int i = 6; i < 10; i++)
      tv[i] = '{0, int'($urandom_range(32, 1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                int'($urandom_range(20, 3)), START, 0};
    repeat (3) @(negedge clk);
    check_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) run_vec(tv[i]);
`ifdef EAGLESONG_HOST_TIMEOUT_EN
    timeout_test();
`else
    run_vec('{0, 10, 1'b0, 1'b0, 300, START, 0});
`endif
    reset_mid_emit();
    run_vec('{0, 17, 1'b0, 1'b1, 5, START, 0});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
